fp_div64_issue: RTL
===================

# fp_div64_issue

Issue/retire controller placed directly upstream of the multi-cycle 64-bit FP divider with normalize and round (`fpDivide64nr`). It accepts divide requests over a valid/ready interface and buffers them in a small FIFO. It launches one divide at a time with a single-cycle `ld` pulse and holds the operands stable while the divide runs. It then detects completion from the divider's `done` level and presents the tagged result downstream over a second valid/ready interface. A watchdog converts a hung divide into a quiet-NaN result with an error flag.

## Interface
Parameters:
- `DEPTH`, default 2: request FIFO entries; must be a power of two, 2..8.
- `TAGW`, default 4: width of the request tag.
- `TIMEOUT`, default 255: maximum number of WAIT cycles before the watchdog fires; must be at least 1 and below 2^16.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `ce`, in, 1: clock enable. When low, all state is frozen.
- `req_valid`, in, 1: a request is offered.
- `req_ready`, out, 1: the FIFO can accept a request; equal to `!full`.
- `req_a`, in, 64: dividend, of type FP64.
- `req_b`, in, 64: divisor, of type FP64.
- `req_rm`, in, 3: rounding mode.
- `req_tag`, in, TAGW: request tag, returned with the result.
- `div_ld`, out, 1: load pulse to the divider.
- `div_a`, out, 64: dividend to the divider.
- `div_b`, out, 64: divisor to the divider.
- `div_rm`, out, 3: rounding mode to the divider.
- `div_done`, in, 1: divider done level.
- `div_o`, in, 64: divider result.
- `div_ovf`, in, 1: divider overflow flag.
- `div_unf`, in, 1: divider underflow flag.
- `res_valid`, out, 1: a result is presented.
- `res_ready`, in, 1: downstream accepts the result.
- `res_o`, out, 64: result value.
- `res_tag`, out, TAGW: tag of the request that produced the result.
- `res_ovf`, out, 1: result overflow flag.
- `res_unf`, out, 1: result underflow flag.
- `res_timeout`, out, 1: the result was produced by the watchdog.

## Operation
- **FIFO.**
  - A push happens when `req_valid & req_ready`.
  - A pop happens on the cycle the FSM leaves IDLE for LOAD.
  - A push and a pop in the same cycle are legal and leave the count unchanged.
  - A push while the FIFO is full is impossible, because `req_ready` is low.
  - The read and write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, LOAD, WAIT_LO, WAIT_HI, RESULT.
- **IDLE.**
  - If the FIFO is non-empty: pop the head into the operand register (a, b, rm, tag) and go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD.**
  - `div_ld` = 1 for exactly this one cycle.
  - Next state is WAIT_LO.
  - The watchdog counter is cleared.
- **WAIT_LO.** `div_done` is high at reset and stays stale-high for several cycles after `ld`, so the controller must first observe it low.
  - When `div_done` = 0, go to WAIT_HI.
- **WAIT_HI.**
  - When `div_done` = 1, capture `div_o`, `div_ovf` and `div_unf` into the result register, set `res_timeout` = 0, and go to RESULT.
- **Watchdog.**
  - The counter increments on every `ce` cycle spent in WAIT_LO or WAIT_HI.
  - When the counter reaches TIMEOUT, go to RESULT instead, with `res_o` = 0x7FF8_0000_0000_0000, `res_ovf` = 0, `res_unf` = 0 and `res_timeout` = 1.
  - If `div_done` = 1 in WAIT_HI on the same cycle the counter reaches TIMEOUT, the real result wins.
- **RESULT.**
  - `res_valid` = 1. The result outputs are held stable until `res_ready`.
  - On `res_ready`:
    - FIFO non-empty: pop and go directly to LOAD, so there is no IDLE bubble.
    - FIFO empty: go to IDLE.
- **Operand outputs.** `div_a`, `div_b` and `div_rm` are driven from the operand register and stay constant from LOAD until the state leaves RESULT.
- **Result ordering.** Results are returned in request order, one outstanding divide at a time.

## Timing
- **Reset values.**
  - Registers: FIFO empty; FSM in IDLE; counter = 0; operand and result registers = 0.
  - Outputs: `req_ready` = 1, `div_ld` = 0, `res_valid` = 0, `res_timeout` = 0, all data outputs = 0.
- **Reset mid-operation** discards all queued and in-flight requests with no result emitted. The divider shares `rst`.
- **Clock enable.** `ce` = 0 freezes the FSM, FIFO, counter and outputs. `div_ld` remains at its current value; the divider is gated by the same `ce`.
- **Request latency.** Accept at cycle 0, `div_ld` at cycle 2 when the FSM is idle.
- **Result latency.** `res_valid` rises on the cycle after `div_done` is first seen high in WAIT_HI.
- **Throughput.** One divide per (divider latency + 3) cycles when `res_ready` is held high.
- **Output timing.** All outputs come from registers or FSM state decode; there is no combinational path from `res_ready` or `div_done` to any output. `req_ready` depends only on the FIFO count.

## Structure
- **fp64Pkg:**
  - use the existing `FP64` typedef;
  - add localparam `FP64_QNAN_WDT` = 64'h7FF8000000000000;
  - add an enum `div_issue_state_e` encoding the five FSM states.
- **Sub-module:** `fp_issue_fifo`, a generic synchronous FIFO parameterized by WID and DEPTH, with full/empty/count outputs. The top level contains the FSM, operand register, result register and watchdog.

## Test plan
- **Single divide.** a = 0x3FF0000000000000 (1.0), b = 0x4000000000000000 (2.0), tag = 5, `res_ready` = 1 → `res_o` = 0x3FE0000000000000, `res_tag` = 5, `res_timeout` = 0, `div_ld` seen exactly once.
- **Back-to-back with DEPTH = 2.** Send 3 requests (6/3, 9/3, 1/4) on consecutive cycles → `req_ready` drops after 2 are queued; results are 2.0, 3.0 and 0.25 in tag order; LOAD follows RESULT with no IDLE cycle.
- **Backpressure.** Hold `res_ready` = 0 for 20 cycles after `res_valid` → outputs are stable and no new `div_ld` is issued; releasing `res_ready` completes the handshake in 1 cycle.
- **Watchdog.** Model `div_done` stuck at 1 with TIMEOUT = 16 → after 16 WAIT cycles `res_o` = 0x7FF8000000000000 and `res_timeout` = 1; the next request proceeds normally.
- **Reset during WAIT_HI with 1 queued request.** Assert `rst` for 1 cycle → `res_valid` is never asserted for either request; `req_ready` = 1; FSM in IDLE.
- **Clock enable.** Toggle `ce` 0/1 every cycle during a divide → the same result and tag as the ungated run, and no duplicate `div_ld`.

Source files
------------

// File: rtl/fp_div64_issue_pkg.sv
// Shared FP64 types, constants and issue-controller state encoding.
package fp64Pkg;

    typedef logic [63:0] FP64;

    // Quiet NaN returned when the watchdog gives up on a divide
    localparam FP64 FP64_QNAN_WDT = 64'h7FF8000000000000;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESULT  = 3'd4
    } div_issue_state_e;

    // Operand payload carried through the request FIFO
    typedef struct packed {
        FP64        a;
        FP64        b;
        logic [2:0] rm;
    } div_operands_t;

endpackage

// File: rtl/fp_issue_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module fp_issue_fifo #(
    parameter int unsigned WID   = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           push,
    input  logic [WID-1:0]                 wdata,
    input  logic                           pop,
    output logic [WID-1:0]                 rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = ce & push & ~full;
    assign do_pop  = ce & pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_div64_issue.sv
// Issue/retire controller for the multi-cycle FP64 divider with watchdog.
module fp_div64_issue
    import fp64Pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            req_valid,
    output logic            req_ready,
    input  FP64             req_a,
    input  FP64             req_b,
    input  logic [2:0]      req_rm,
    input  logic [TAGW-1:0] req_tag,
    output logic            div_ld,
    output FP64             div_a,
    output FP64             div_b,
    output logic [2:0]      div_rm,
    input  logic            div_done,
    input  FP64             div_o,
    input  logic            div_ovf,
    input  logic            div_unf,
    output logic            res_valid,
    input  logic            res_ready,
    output FP64             res_o,
    output logic [TAGW-1:0] res_tag,
    output logic            res_ovf,
    output logic            res_unf,
    output logic            res_timeout
);

    localparam int unsigned OPW  = $bits(div_operands_t);
    localparam int unsigned FW   = OPW + TAGW;
    localparam int unsigned CW   = $clog2(DEPTH+1);
    localparam int unsigned WDW  = 16;

    div_issue_state_e state;
    div_operands_t    req_op;
    div_operands_t    head_op;
    div_operands_t    op_q;
    logic [TAGW-1:0]  head_tag;
    logic [TAGW-1:0]  tag_q;
    logic [FW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;
    logic [WDW-1:0]   wdog;
    logic [WDW-1:0]   wdog_inc;
    logic             wdog_hit;

    assign req_op   = '{a: req_a, b: req_b, rm: req_rm};
    assign {head_op, head_tag} = fifo_rdata;

    assign push = req_valid & ~fifo_full;
    assign pop  = ~fifo_empty &
                  ((state == S_IDLE) | ((state == S_RESULT) & res_ready));

    assign wdog_inc = wdog + WDW'(1);
    assign wdog_hit = (wdog_inc == WDW'(TIMEOUT));

    assign req_ready = (fifo_count != CW'(DEPTH));
    assign div_ld    = (state == S_LOAD);
    assign res_valid = (state == S_RESULT);
    assign div_a     = op_q.a;
    assign div_b     = op_q.b;
    assign div_rm    = op_q.rm;

    fp_issue_fifo #(
        .WID   (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .push  (push),
        .wdata ({req_op, req_tag}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue FSM with operand register, result register and watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wdog        <= '0;
            op_q        <= '0;
            tag_q       <= '0;
            res_o       <= '0;
            res_tag     <= '0;
            res_ovf     <= 1'b0;
            res_unf     <= 1'b0;
            res_timeout <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_q  <= head_op;
                        tag_q <= head_tag;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    wdog  <= '0;
                    state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    // done is stale-high after ld; it must be seen low first
                    wdog <= wdog_inc;
                    if (wdog_hit) begin
                        res_o       <= FP64_QNAN_WDT;
                        res_ovf     <= 1'b0;
                        res_unf     <= 1'b0;
                        res_timeout <= 1'b1;
                        res_tag     <= tag_q;
                        state       <= S_RESULT;
                    end else if (!div_done) begin
                        state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    // A real completion beats a coincident watchdog expiry
                    wdog <= wdog_inc;
                    if (div_done) begin
                        res_o       <= div_o;
                        res_ovf     <= div_ovf;
                        res_unf     <= div_unf;
                        res_timeout <= 1'b0;
                        res_tag     <= tag_q;
                        state       <= S_RESULT;
                    end else if (wdog_hit) begin
                        res_o       <= FP64_QNAN_WDT;
                        res_ovf     <= 1'b0;
                        res_unf     <= 1'b0;
                        res_timeout <= 1'b1;
                        res_tag     <= tag_q;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        if (!fifo_empty) begin
                            op_q  <= head_op;
                            tag_q <= head_tag;
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
